// File: rtl/fill_fifo_drain_pkg.sv
// Shared definitions for the fill FIFO drain path.
// Holds the AXI width defaults (overridable by defining the AXI_* macros
// before compilation), AXI burst/response encodings, the drain FSM state
// type and the fill_entry_t packing shared with the arbiter side.
// No ports.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 512
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ID
`define AXI_ID 0
`endif

package fill_fifo_drain_pkg;

  localparam int unsigned AXI_ADDR_WIDTH_DFLT = `AXI_ADDR_WIDTH;
  localparam int unsigned AXI_DATA_WIDTH_DFLT = `AXI_DATA_WIDTH;
  localparam int unsigned AXI_ID_WIDTH_DFLT   = `AXI_ID_WIDTH;
  localparam int unsigned AXI_ID_DFLT         = `AXI_ID;

  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_RESP
  } state_e;

  // FIFO word layout: address in the upper bits, line data in the lower bits.
  typedef struct packed {
    logic [AXI_ADDR_WIDTH_DFLT-1:0] addr;
    logic [AXI_DATA_WIDTH_DFLT-1:0] data;
  } fill_entry_t;

  // SLVERR and DECERR both have bit 1 set; OKAY/EXOKAY are successes.
  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:  return 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fill_fifo_drain_axi_w.sv
// Independent AW/W valid tracker for a single-beat AXI write.
// start_i arms both channels; each valid drops the cycle after its own
// handshake. done_o is high in the cycle in which the last outstanding
// channel handshakes (or whenever both are already complete).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start_i             arm AW and W for a new transfer
//   awready_i/wready_i  channel readies
//   awvalid_o/wvalid_o  channel valids
//   aw_hs_o/w_hs_o      handshake strobes this cycle
//   done_o              both channels complete by the end of this cycle
module fill_fifo_drain_axi_w (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic awready_i,
  input  logic wready_i,
  output logic awvalid_o,
  output logic wvalid_o,
  output logic aw_hs_o,
  output logic w_hs_o,
  output logic done_o
);

  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  // A ready seen while the matching valid is low never counts.
  assign awvalid_o = !aw_done_q;
  assign wvalid_o  = !w_done_q;
  assign aw_hs_o   = awvalid_o && awready_i;
  assign w_hs_o    = wvalid_o && wready_i;
  assign done_o    = (aw_done_q || aw_hs_o) && (w_done_q || w_hs_o);

  always_comb begin
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    if (start_i) begin
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end else begin
      if (aw_hs_o) aw_done_d = 1'b1;
      if (w_hs_o)  w_done_d  = 1'b1;
    end
  end

  // "Done" is the idle condition, so reset leaves both valids low.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_done_q <= 1'b1;
      w_done_q  <= 1'b1;
    end else begin
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: rtl/fill_fifo_drain.sv
// Fill FIFO drain: pops one {addr, line} entry at a time and writes it out
// as a single-beat AXI write (AW/W/B), one transaction in flight.
// Optional feature macro: FILL_DRAIN_PERF_EN adds drain_cnt_o (completed
// B handshakes, wrapping), stall_cnt_o (SEND/RESP cycles with no handshake,
// saturating) and a BID check.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   fill_fifo_*                  FIFO read port (data valid the cycle after rden)
//   aw*/w*/b*                    AXI write master channels
//   busy_o                       not idle
//   err_o                        sticky error on SLVERR/DECERR response
module fill_fifo_drain
  import fill_fifo_drain_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AXI_ADDR_WIDTH_DFLT,
  parameter int unsigned DATA_WIDTH = AXI_DATA_WIDTH_DFLT,
  parameter int unsigned ID_WIDTH   = AXI_ID_WIDTH_DFLT,
  parameter int unsigned ID         = AXI_ID_DFLT
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fill_fifo_empty_i,
  output logic                             fill_fifo_rden_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_fifo_rdata_i,
  output logic [ID_WIDTH-1:0]              awid_o,
  output logic [ADDR_WIDTH-1:0]            awaddr_o,
  output logic [7:0]                       awlen_o,
  output logic [2:0]                       awsize_o,
  output logic [1:0]                       awburst_o,
  output logic                             awvalid_o,
  input  logic                             awready_i,
  output logic [DATA_WIDTH-1:0]            wdata_o,
  output logic [DATA_WIDTH/8-1:0]          wstrb_o,
  output logic                             wlast_o,
  output logic                             wvalid_o,
  input  logic                             wready_i,
  input  logic [ID_WIDTH-1:0]              bid_i,
  input  logic [1:0]                       bresp_i,
  input  logic                             bvalid_i,
  output logic                             bready_o,
  output logic                             busy_o,
  output logic                             err_o
`ifdef FILL_DRAIN_PERF_EN
  ,
  output logic [31:0]                      drain_cnt_o,
  output logic [31:0]                      stall_cnt_o
`endif
);

  localparam int unsigned SIZE = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((64'd1 << SIZE) - 64'd1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;
  logic                    aw_hs, w_hs, b_hs, send_done;
  logic                    unused_bid;

  assign unused_bid = ^bid_i;

  fill_fifo_drain_axi_w u_axi_w (
    .clk       (clk),
    .rst       (rst),
    .start_i   (state_q == S_LOAD),
    .awready_i (awready_i),
    .wready_i  (wready_i),
    .awvalid_o (awvalid_o),
    .wvalid_o  (wvalid_o),
    .aw_hs_o   (aw_hs),
    .w_hs_o    (w_hs),
    .done_o    (send_done)
  );

  always_comb begin
    state_d          = state_q;
    fill_fifo_rden_o = 1'b0;
    bready_o         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        fill_fifo_rden_o = !fill_fifo_empty_i;
        if (!fill_fifo_empty_i) state_d = S_LOAD;
      end
      S_LOAD: state_d = S_SEND;
      S_SEND: if (send_done) state_d = S_RESP;
      S_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign b_hs = bready_o && bvalid_i;

  // Read data arrives the cycle after the pop, i.e. while in S_LOAD.
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    err_d  = err_q | (b_hs && resp_is_err(bresp_i));
    if (state_q == S_LOAD) begin
      addr_d = fill_fifo_rdata_i[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH] & ADDR_MASK;
      data_d = fill_fifo_rdata_i[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign awid_o    = ID_WIDTH'(ID);
  assign awaddr_o  = addr_q;
  assign awlen_o   = 8'd0;
  assign awsize_o  = 3'(SIZE);
  assign awburst_o = AXI_BURST_INCR;
  assign wdata_o   = data_q;
  assign wstrb_o   = '1;
  assign wlast_o   = wvalid_o;
  assign busy_o    = (state_q != S_IDLE);
  assign err_o     = err_q;

`ifdef FILL_DRAIN_PERF_EN
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] drain_cnt_q, drain_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_cyc;

  assign stall_cyc = ((state_q == S_SEND) || (state_q == S_RESP)) && !(aw_hs || w_hs || b_hs);

  always_comb begin
    drain_cnt_d = b_hs ? drain_cnt_q + 32'd1 : drain_cnt_q;
    stall_cnt_d = stall_cyc ? sat_inc32(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign drain_cnt_o = drain_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

  // With one transaction in flight, every response must carry our own ID.
  assert property (@(posedge clk) disable iff (rst) b_hs |-> (bid_i == ID_WIDTH'(ID)));
`endif

endmodule

// File: tb/tb_fill_fifo_drain.sv
module tb_fill_fifo_drain;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int IW = 4;
  localparam int NB = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          empty = 1'b1;
  logic          rden;
  logic [AW+DW-1:0] rdata = '0;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          awvalid, awready = 1'b0;
  logic [DW-1:0] wdata;
  logic [NB-1:0] wstrb;
  logic          wlast, wvalid, wready = 1'b0;
  logic [IW-1:0] bid = '0;
  logic [1:0]    bresp = 2'b00;
  logic          bvalid = 1'b0, bready, busy, err;
`ifdef FILL_DRAIN_PERF_EN
  logic [31:0]   drain_cnt, stall_cnt;
`endif

  fill_fifo_drain dut (
    .clk(clk), .rst(rst),
    .fill_fifo_empty_i(empty), .fill_fifo_rden_o(rden), .fill_fifo_rdata_i(rdata),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
    .awburst_o(awburst), .awvalid_o(awvalid), .awready_i(awready),
    .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready),
    .busy_o(busy), .err_o(err)
`ifdef FILL_DRAIN_PERF_EN
    , .drain_cnt_o(drain_cnt), .stall_cnt_o(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // FIFO model and observation state
  logic [AW-1:0] fifo_a[$];
  logic [DW-1:0] fifo_d[$];
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];
  bit            b_err_log[$];
  int            b_cyc_log[$];
  int            pop_cyc_log[$];
  logic [1:0]    resp_q[$];
  int cyc = 0, pops = 0, viol = 0, rden_cycles = 0;
  int aw_n = 0, w_n = 0, b_n_hs = 0, b_issued = 0;
  int awv_cycles = 0, wv_cycles = 0, aw_cyc = 0, w_cyc = 0;
  int bready_rise_cyc = -1, err_rise_cyc = -1;
  bit pop_pend = 1'b0;
  logic [7:0] last_awlen;
  logic [2:0] last_awsize;
  logic [1:0] last_awburst;
  logic [IW-1:0] last_awid;
  logic last_wlast;
  logic [NB-1:0] last_wstrb;
  int cfg_aw_stall = 0, cfg_w_stall = 0, cfg_b_delay = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO read side plus protocol monitor; inputs are stable from here to the next posedge.
  initial begin
    logic pv_aw, pv_w, pv_awhs, pv_whs, pv_bready, pv_err;
    logic [AW-1:0] pv_awaddr;
    logic [DW-1:0] pv_wdata;
    logic aw_hs, w_hs, b_hs;
    pv_aw = 0; pv_w = 0; pv_awhs = 0; pv_whs = 0; pv_bready = 0; pv_err = 0;
    pv_awaddr = '0; pv_wdata = '0;
    forever begin
      @(negedge clk);
      if (pop_pend) begin
        rdata = {fifo_a.pop_front(), fifo_d.pop_front()};
        pop_pend = 1'b0;
      end
      empty = (fifo_a.size() == 0);
      #1;
      if (!rst) begin
        aw_hs = awvalid && awready;
        w_hs  = wvalid && wready;
        b_hs  = bvalid && bready;
        if (rden === 1'b1) begin
          rden_cycles++;
          if (empty || busy) viol++;
          else begin pop_pend = 1'b1; pops++; pop_cyc_log.push_back(cyc); end
        end
        if (awvalid) awv_cycles++;
        if (wvalid) wv_cycles++;
        if (pv_aw && !pv_awhs && (!awvalid || awaddr !== pv_awaddr)) viol++;
        if (pv_w && !pv_whs && (!wvalid || wdata !== pv_wdata)) viol++;
        if (pv_awhs && awvalid) viol++;
        if (pv_whs && wvalid) viol++;
        if (bready && !(aw_n > b_n_hs && w_n > b_n_hs)) viol++;
        if (bready && !pv_bready) bready_rise_cyc = cyc;
        if (err && !pv_err) err_rise_cyc = cyc;
        if (aw_hs) begin
          aw_log.push_back(awaddr); aw_n++; aw_cyc = cyc;
          last_awlen = awlen; last_awsize = awsize; last_awburst = awburst; last_awid = awid;
        end
        if (w_hs) begin
          w_log.push_back(wdata); w_n++; w_cyc = cyc;
          last_wlast = wlast; last_wstrb = wstrb;
        end
        if (b_hs) begin
          b_err_log.push_back(err); b_cyc_log.push_back(cyc); b_n_hs++;
        end
        pv_aw = awvalid; pv_w = wvalid; pv_awhs = aw_hs; pv_whs = w_hs;
        pv_awaddr = awaddr; pv_wdata = wdata; pv_bready = bready; pv_err = err;
      end else begin
        pv_aw = 0; pv_w = 0; pv_awhs = 0; pv_whs = 0; pv_bready = 0; pv_err = 0;
      end
    end
  end

  // AXI slave responder: ready after a configured stall, B after a configured delay.
  initial begin
    int aw_wait, w_wait, b_wait;
    aw_wait = 0; w_wait = 0; b_wait = 0;
    forever begin
      @(posedge clk);
      #2;
      if (awvalid === 1'b1) begin awready = (aw_wait >= cfg_aw_stall); aw_wait++; end
      else begin aw_wait = 0; awready = (cfg_aw_stall == 0); end
      if (wvalid === 1'b1) begin wready = (w_wait >= cfg_w_stall); w_wait++; end
      else begin w_wait = 0; wready = (cfg_w_stall == 0); end
      if (bvalid && b_n_hs > b_issued) begin
        bvalid = 1'b0; b_issued++; b_wait = 0;
      end
      if (!bvalid && aw_n > b_issued && w_n > b_issued) begin
        if (b_wait >= cfg_b_delay) begin
          bvalid = 1'b1;
          bresp = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
          bid = '0;
        end else b_wait++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] a);
    return (a / NB) * NB;
  endfunction

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    fifo_a.push_back(a);
    fifo_d.push_back(d);
  endtask

  task automatic wait_b(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (b_n_hs < target && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (b_n_hs < target) begin
      errors++;
      $display("FAIL %s_timeout responses got %0d want %0d", nm, b_n_hs, target);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({awvalid, wvalid, bready, rden, busy, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000", {awvalid, wvalid, bready, rden, busy, err});
    end
    checks++;
    if (awaddr !== '0 || wdata !== '0) begin
      errors++; $display("FAIL reset_hold awaddr %h want 0", awaddr);
    end
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_single();
    int p0, a0, w0, b0, r0, v0;
    logic [DW-1:0] d;
    p0 = pops; a0 = aw_log.size(); w0 = w_log.size(); b0 = b_n_hs; r0 = rden_cycles; v0 = viol;
    for (int i = 0; i < NB; i++) d[i*8 +: 8] = 8'hA5;
    push(32'h0000_1040, d);
    wait_b(b0 + 1, 50, "single");
    @(posedge clk); #2;
    checks++;
    if (rden_cycles - r0 !== 1 || pops - p0 !== 1) begin
      errors++; $display("FAIL single_rden cycles %0d pops %0d want 1", rden_cycles - r0, pops - p0);
    end
    checks++;
    if (aw_log[a0] !== 32'h0000_1040) begin
      errors++; $display("FAIL single_awaddr got %h want 00001040", aw_log[a0]);
    end
    checks++;
    if ({last_awlen, last_awsize, last_awburst, last_awid} !== {8'd0, 3'd6, 2'b01, 4'd0}) begin
      errors++; $display("FAIL single_awattr len %0d size %0d burst %b id %0d", last_awlen, last_awsize, last_awburst, last_awid);
    end
    checks++;
    if (last_wlast !== 1'b1 || last_wstrb !== {NB{1'b1}} || w_log[w0] !== d) begin
      errors++; $display("FAIL single_w wlast %b wstrb %h", last_wlast, last_wstrb);
    end
    checks++;
    if (b_cyc_log[b0] - pop_cyc_log[p0] !== 3) begin
      errors++; $display("FAIL single_latency got %0d want 3", b_cyc_log[b0] - pop_cyc_log[p0]);
    end
    checks++;
    if (busy !== 1'b0 || viol !== v0) begin
      errors++; $display("FAIL single_after busy %b violations %0d want 0", busy, viol - v0);
    end
  endtask

  task automatic test_unaligned();
    int a0, w0, b0;
    logic [DW-1:0] d;
    a0 = aw_log.size(); w0 = w_log.size(); b0 = b_n_hs;
    d = rand_line();
    push(32'h0000_107F, d);
    wait_b(b0 + 1, 50, "unaligned");
    checks++;
    if (aw_log[a0] !== 32'h0000_1040 || w_log[w0] !== d) begin
      errors++; $display("FAIL unaligned_awaddr got %h want 00001040", aw_log[a0]);
    end
  endtask

  task automatic test_aw_stall();
    int a0, b0, v0, awv0, wv0;
    logic [AW-1:0] a;
    a0 = aw_log.size(); b0 = b_n_hs; v0 = viol; awv0 = awv_cycles; wv0 = wv_cycles;
    cfg_aw_stall = 5;
    a = $urandom;
    push(a, rand_line());
    wait_b(b0 + 1, 60, "aw_stall");
    checks++;
    if (wv_cycles - wv0 !== 1 || awv_cycles - awv0 !== 6) begin
      errors++; $display("FAIL aw_stall_valids wvalid %0d want 1 awvalid %0d want 6", wv_cycles - wv0, awv_cycles - awv0);
    end
    checks++;
    if (aw_cyc - w_cyc !== 5) begin
      errors++; $display("FAIL aw_stall_gap got %0d want 5", aw_cyc - w_cyc);
    end
    checks++;
    if (bready_rise_cyc !== aw_cyc + 1) begin
      errors++; $display("FAIL aw_stall_bready got cycle %0d want %0d", bready_rise_cyc, aw_cyc + 1);
    end
    checks++;
    if (viol !== v0 || aw_log[a0] !== line_addr(a)) begin
      errors++; $display("FAIL aw_stall_stable violations %0d addr %h want %h", viol - v0, aw_log[a0], line_addr(a));
    end
    cfg_aw_stall = 0;
  endtask

  // Drains a batch and compares order, content and per-entry spacing with the model.
  task automatic run_batch(input int n, input string nm);
    int p0, a0, w0, b0, v0, sp;
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    p0 = pops; a0 = aw_log.size(); w0 = w_log.size(); b0 = b_n_hs; v0 = viol;
    sp = 4 + cfg_b_delay + ((cfg_aw_stall > cfg_w_stall) ? cfg_aw_stall : cfg_w_stall);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = $urandom; d = rand_line();
      ea.push_back(line_addr(a)); ed.push_back(d);
      push(a, d);
    end
    wait_b(b0 + n, 40 * n, nm);
    checks++;
    if (pops - p0 !== n || aw_log.size() - a0 !== n || w_log.size() - w0 !== n) begin
      errors++; $display("FAIL %s_counts pops %0d aw %0d w %0d want %0d", nm, pops - p0, aw_log.size() - a0, w_log.size() - w0, n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (aw_log[a0+i] !== ea[i] || w_log[w0+i] !== ed[i]) begin
        errors++; $display("FAIL %s_entry%0d awaddr %h want %h", nm, i, aw_log[a0+i], ea[i]);
      end
      if (i > 0) begin
        checks++;
        if (pop_cyc_log[p0+i] - pop_cyc_log[p0+i-1] !== sp) begin
          errors++; $display("FAIL %s_spacing%0d got %0d want %0d", nm, i, pop_cyc_log[p0+i] - pop_cyc_log[p0+i-1], sp);
        end
      end
    end
    checks++;
    if (viol !== v0) begin
      errors++; $display("FAIL %s_protocol violations %0d want 0", nm, viol - v0);
    end
  endtask

  task automatic test_back_to_back();
    cfg_b_delay = 3;
    run_batch(3, "b2b");
    cfg_b_delay = 0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      cfg_aw_stall = $urandom_range(0, 3);
      cfg_w_stall  = $urandom_range(0, 3);
      cfg_b_delay  = $urandom_range(0, 3);
      for (int i = 0; i < 5; i++) resp_q.push_back(($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00);
      run_batch(5, "random");
    end
    cfg_aw_stall = 0; cfg_w_stall = 0; cfg_b_delay = 0;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL random_err got %b want 0", err);
    end
  endtask

  task automatic test_error();
    int b0;
    b0 = b_n_hs;
    resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b00);
    run_batch(3, "error");
    checks++;
    if (b_err_log[b0+1] !== 1'b0 || b_err_log[b0+2] !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL error_sticky at2 %b at3 %b now %b want 0 1 1", b_err_log[b0+1], b_err_log[b0+2], err);
    end
    checks++;
    if (err_rise_cyc !== b_cyc_log[b0+1] + 1) begin
      errors++; $display("FAIL error_timing got cycle %0d want %0d", err_rise_cyc, b_cyc_log[b0+1] + 1);
    end
  endtask

  task automatic test_empty_park();
    run_batch(2, "park");
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({awvalid, wvalid, bready, rden, busy, empty} !== 6'b000001) begin
      errors++; $display("FAIL park_idle got %b want 000001", {awvalid, wvalid, bready, rden, busy, empty});
    end
  endtask

  task automatic test_reset_in_send();
    int n;
    cfg_aw_stall = 50;
    push($urandom, rand_line());
    n = 0;
    while (awvalid !== 1'b1 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (awvalid !== 1'b1) begin
      errors++; $display("FAIL rst_send_reach awvalid %b want 1", awvalid);
    end
    rst = 1'b1;
    @(posedge clk); #2;
    checks++;
    if ({awvalid, wvalid, bready, rden, busy, err} !== 6'b0) begin
      errors++; $display("FAIL rst_send_ctrl got %b want 000000", {awvalid, wvalid, bready, rden, busy, err});
    end
`ifdef FILL_DRAIN_PERF_EN
    checks++;
    if (drain_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_send_drain_cnt got %0d want 0", drain_cnt);
    end
`endif
    rst = 1'b0;
    cfg_aw_stall = 0;
    @(posedge clk); #2;
  endtask

  initial begin
    test_reset();
    test_single();
    test_unaligned();
    test_aw_stall();
    test_back_to_back();
    test_random();
    test_error();
    test_empty_park();
    test_reset_in_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
